mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port synchronous `mem` array. It accepts read/write requests from two independent requesters and grants them round-robin. For each granted request it drives the memory's `rdEn`/`wrEn`/`Addr`/tristate `Data` bus for exactly one access cycle, then returns an acknowledge and, for reads, the read data. It sits between the datapath clients and the `mem` instance, and is the only driver of the memory's control pins.

---
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter/sequencer for a single-port synchronous memory.
// Each grant produces one access cycle followed by one ack cycle, then returns to IDLE.
module mem_arbiter #(
  parameter int MEMDEPTH  = 256,
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = $clog2(MEMDEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDRWIDTH-1:0] addr0,
  input  logic [ADDRWIDTH-1:0] addr1,
  input  logic [DATAWIDTH-1:0] wdata0,
  input  logic [DATAWIDTH-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [DATAWIDTH-1:0] rdata0,
  output logic [DATAWIDTH-1:0] rdata1,
  output logic                 busy,
  output logic                 memRdEn,
  output logic                 memWrEn,
  output logic [ADDRWIDTH-1:0] memAddr,
  inout  tri   [DATAWIDTH-1:0] memData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_t;

  state_t                 state_reg, state_next;
  logic                   last_grant_reg, last_grant_next;
  logic                   winner_reg, winner_next;
  logic [ADDRWIDTH-1:0]   addr_reg, addr_next;
  logic [DATAWIDTH-1:0]   wdata_reg, wdata_next;
  logic [1:0]             req_vec;
  logic                   grant;

  assign req_vec = {req1, req0};

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    winner_next     = winner_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    grant           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_vec != 2'b00) begin
          // On a tie the port that was not granted last wins; otherwise the sole requester.
          grant           = (req_vec == 2'b11) ? ~last_grant_reg : req_vec[1];
          winner_next     = grant;
          last_grant_next = grant;
          addr_next       = grant ? addr1 : addr0;
          wdata_next      = grant ? wdata1 : wdata0;
          state_next      = (grant ? we1 : we0) ? WRITE : READ;
        end
      end
      READ:    state_next = ACK;
      WRITE:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      winner_reg     <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      winner_reg     <= winner_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
    end
  end

  // All memory-side outputs decode registered state only, so no input-to-output paths exist.
  assign busy    = (state_reg != IDLE);
  assign memRdEn = (state_reg == READ);
  assign memWrEn = (state_reg == WRITE);
  assign memAddr = (memRdEn || memWrEn) ? addr_reg : '0;
  assign memData = memWrEn ? wdata_reg : 'z;
  assign ack0    = (state_reg == ACK) && (winner_reg == 1'b0);
  assign ack1    = (state_reg == ACK) && (winner_reg == 1'b1);

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DATAWIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_reg <= '0;
      end else if (state_reg == READ && winner_reg == 1'(gi)) begin
        rdata_reg <= memData;
      end
    end

    if (gi == 0) begin : g_out0
      assign rdata0 = rdata_reg;
    end else begin : g_out1
      assign rdata1 = rdata_reg;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timing-arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, mem_rd_en, mem_wr_en;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  tri   [DW-1:0] mem_data;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEMDEPTH(256), .DATAWIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .memRdEn(mem_rd_en), .memWrEn(mem_wr_en),
    .memAddr(mem_addr), .memData(mem_data)
  );

  // Attached memory: drives the bus while read-enabled, commits writes on the edge.
  logic [DW-1:0] mem_array [256];
  bit            mem_clear = 1'b1;
  assign mem_data = mem_rd_en ? mem_array[mem_addr] : 'z;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem_array[i] <= '0;
    end else if (mem_wr_en) begin
      mem_array[mem_addr] <= mem_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a grant at edge E means access in cycle E, ack in cycle E+1,
  // idle in E+2 and the next sample at edge E+3.
  int            cyc = 0;
  int            acc_cyc = 0;
  bit            have = 1'b0;
  bit            last_g = 1'b1;
  bit            txn_port = 1'b0;
  op_t           txn = '0;
  logic [DW-1:0] exp_rd [2];
  logic [DW-1:0] ref_mem [256];

  initial begin
    bit in_acc, in_ack, p;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (have && acc_cyc == cyc - 1) begin
        if (txn.we) ref_mem[txn.addr] = txn.wdata;
        else if (!reset) exp_rd[txn_port] = ref_mem[txn.addr];
      end
      if (reset) begin
        have      = 1'b0;
        last_g    = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
      end else if ((!have || cyc >= acc_cyc + 3) && (req0 || req1)) begin
        p        = (req0 && req1) ? !last_g : req1;
        last_g   = p;
        have     = 1'b1;
        acc_cyc  = cyc;
        txn_port = p;
        txn      = p ? {we1, addr1, wdata1} : {we0, addr0, wdata0};
      end
      @(negedge clk);
      in_acc = have && (cyc == acc_cyc);
      in_ack = have && (cyc == acc_cyc + 1);
      chk("busy",    32'(busy),      32'(in_acc || in_ack));
      chk("rd_en",   32'(mem_rd_en), 32'(in_acc && !txn.we));
      chk("wr_en",   32'(mem_wr_en), 32'(in_acc && txn.we));
      chk("addr",    32'(mem_addr),  in_acc ? 32'(txn.addr) : 32'd0);
      chk("ack0",    32'(ack0),      32'(in_ack && txn_port == 1'b0));
      chk("ack1",    32'(ack1),      32'(in_ack && txn_port == 1'b1));
      chk("rdata0",  32'(rdata0),    32'(exp_rd[0]));
      chk("rdata1",  32'(rdata1),    32'(exp_rd[1]));
      chk("rd_wr_excl", 32'(mem_rd_en & mem_wr_en), 32'd0);
      if (in_acc && txn.we) chk("bus_data", 32'(mem_data), 32'(txn.wdata));
    end
  end

  // Requester side
  op_t           q0 [$];
  op_t           q1 [$];
  op_t           cur [2];
  bit   [1:0]    req_v = 2'b00;
  bit            hold = 1'b1;
  int            wr_cycles = 0;
  int            grant_log [$];
  logic [DW-1:0] last_rd [2];

  task automatic add(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o.we = we; o.addr = a; o.wdata = d;
    if (p == 0) q0.push_back(o); else q1.push_back(o);
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.we = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       o.addr = 8'hFF;
      1:       o.addr = 8'h00;
      default: o.addr = 8'($urandom_range(0, 7));
    endcase
    o.wdata = 16'($urandom_range(0, 65535));
    return o;
  endfunction

  task automatic apply();
    req0 = req_v[0]; we0 = cur[0].we; addr0 = cur[0].addr; wdata0 = cur[0].wdata;
    req1 = req_v[1]; we1 = cur[1].we; addr1 = cur[1].addr; wdata1 = cur[1].wdata;
  endtask

  // Called once per falling edge: retire acked ops, raise the next pending one.
  task automatic drive();
    bit a;
    int qs;
    if (mem_wr_en) wr_cycles++;
    for (int p = 0; p < 2; p++) begin
      a = (p == 1) ? ack1 : ack0;
      if (req_v[p] && a) begin
        grant_log.push_back(p);
        if (!cur[p].we) last_rd[p] = (p == 1) ? rdata1 : rdata0;
        req_v[p] = 1'b0;
      end
      if (!req_v[p]) begin
        qs = (p == 1) ? q1.size() : q0.size();
        if (qs != 0 && (hold || $urandom_range(0, 2) == 0)) begin
          cur[p]   = (p == 1) ? q1.pop_front() : q0.pop_front();
          req_v[p] = 1'b1;
        end else begin
          cur[p] = rand_op();
        end
      end
    end
    apply();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive();
    end
  endtask

  task automatic run_until_done(input int max);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || req_v != 2'b00) && n < max) begin
      @(negedge clk);
      drive();
      n++;
    end
    chk("run_done", 32'(n < max), 32'd1);
  endtask

  task automatic assert_reset_now();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    req_v = 2'b00;
    apply();
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    assert_reset_now();
    release_reset();
  endtask

  task automatic wait_access_then_reset(input bit want_wr, input string name);
    bit found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (want_wr ? mem_wr_en : mem_rd_en) found = 1'b1;
      else drive();
    end
    chk(name, 32'(found), 32'd1);
    assert_reset_now();
    release_reset();
  endtask

  int exp_log4 [4] = '{0, 1, 0, 1};
  int exp_log6 [6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    last_rd[0] = '0;
    last_rd[1] = '0;
    cur[0] = '0;
    cur[1] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mem_clear = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_acks", 32'({ack1, ack0}), 32'd0);
      chk("idle_en",   32'({mem_rd_en, mem_wr_en}), 32'd0);
      chk("idle_addr", 32'(mem_addr), 32'd0);
      chk("idle_rdata", 32'({rdata1, rdata0}), 32'd0);
    end

    // Port 0 write then read back
    hold = 1'b1;
    wr_cycles = 0;
    add(0, 1'b1, 8'h10, 16'hA5A5);
    add(0, 1'b0, 8'h10, 16'h0000);
    run_until_done(50);
    chk("wr_pulse_cycles", 32'(wr_cycles), 32'd1);
    chk("readback_a5a5", 32'(last_rd[0]), 32'h0000A5A5);

    // Simultaneous requests: port 0 wins the first tie, then alternation
    pulse_reset();
    grant_log.delete();
    add(0, 1'b1, 8'h01, 16'h1111);
    add(1, 1'b1, 8'h02, 16'h2222);
    add(0, 1'b0, 8'h01, 16'h0000);
    add(1, 1'b0, 8'h02, 16'h0000);
    run_until_done(60);
    chk("tie_log_len", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("tie_order", 32'(grant_log[i]), 32'(exp_log4[i]));
    chk("readback_1111", 32'(last_rd[0]), 32'h00001111);
    chk("readback_2222", 32'(last_rd[1]), 32'h00002222);

    // Both ports held for six transactions
    pulse_reset();
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    run_until_done(80);
    chk("rr_log_len", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("rr_order", 32'(grant_log[i]), 32'(exp_log6[i]));

    // Reset landing on the WRITE cycle: the write still commits, no ack
    add(0, 1'b1, 8'hFF, 16'hBEEF);
    wait_access_then_reset(1'b1, "saw_write");
    idle(3);
    last_rd[0] = '0;
    add(0, 1'b0, 8'hFF, 16'h0000);
    run_until_done(30);
    chk("readback_beef", 32'(last_rd[0]), 32'h0000BEEF);

    // Reset landing on a READ cycle: rdata cleared, no ack
    add(1, 1'b1, 8'h03, 16'h5A5A);
    add(1, 1'b0, 8'h03, 16'h0000);
    run_until_done(30);
    chk("readback_5a5a", 32'(last_rd[1]), 32'h00005A5A);
    add(1, 1'b0, 8'h03, 16'h0000);
    wait_access_then_reset(1'b0, "saw_read");
    chk("rdata1_cleared", 32'(rdata1), 32'd0);
    idle(3);

    // Randomized traffic with sporadic request timing
    hold = 1'b0;
    for (int i = 0; i < 150; i++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    run_until_done(6000);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
